// File: rtl/bcp_sequencer.sv
// Control FSM for one BCP propagation pass: loads the engine, iterates
// evaluate/capture/check/commit until fixpoint, conflict, error or abort.
module bcp_sequencer #(
    parameter int VAR_NUM      = 8,
    parameter int EVAL_TIMEOUT = 16,
    parameter int CNT_W        = $clog2(VAR_NUM + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             bcp_finish_flag,
    input  logic             unit_any,
    input  logic             conflict,
    output logic             bcp_request,
    output logic             bcp_free_initial,
    output logic             bcp_assignment_initial,
    output logic             vst_sel,
    output logic             bcp_work_en,
    output logic             w_en,
    output logic             conflict_analysis_en,
    output logic             sel_next,
    output logic             rw_en,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] imp_count
);

    localparam int TMR_W = (EVAL_TIMEOUT > 1) ? $clog2(EVAL_TIMEOUT) : 1;

    localparam logic [1:0] ST_FIXPT = 2'b00;
    localparam logic [1:0] ST_CONF  = 2'b01;
    localparam logic [1:0] ST_ERR   = 2'b10;
    localparam logic [1:0] ST_ABORT = 2'b11;

    typedef enum logic [3:0] {
        IDLE, REQ, LD_FREE, LD_ASGN, FETCH, EVAL, CAPT, CONF, CHK, SEL, WR, FIN
    } state_t;

    state_t           state, nxt;
    logic [1:0]       nxt_status;
    logic [TMR_W-1:0] timer;

    always_comb begin
        nxt        = state;
        nxt_status = status;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    nxt        = REQ;
                    nxt_status = ST_FIXPT;
                end
            end
            REQ:     nxt = LD_FREE;
            LD_FREE: nxt = LD_ASGN;
            LD_ASGN: nxt = FETCH;
            FETCH:   nxt = EVAL;
            EVAL: begin
                if (bcp_finish_flag) begin
                    nxt = CAPT;
                end else if (timer == TMR_W'(EVAL_TIMEOUT - 1)) begin
                    nxt        = FIN;
                    nxt_status = ST_ERR;
                end
            end
            CAPT: nxt = CONF;
            CONF: nxt = CHK;
            CHK: begin
                if (conflict) begin
                    nxt        = FIN;
                    nxt_status = ST_CONF;
                end else if (unit_any && imp_count == CNT_W'(VAR_NUM)) begin
                    // Trap here so imp_count can never wrap through another WR.
                    nxt        = FIN;
                    nxt_status = ST_ERR;
                end else if (unit_any) begin
                    nxt = SEL;
                end else begin
                    nxt        = FIN;
                    nxt_status = ST_FIXPT;
                end
            end
            SEL:     nxt = WR;
            WR:      nxt = FETCH;
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort && state != IDLE && state != FIN) begin
            nxt        = FIN;
            nxt_status = ST_ABORT;
        end
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                  <= IDLE;
            timer                  <= '0;
            status                 <= ST_FIXPT;
            imp_count              <= '0;
            bcp_request            <= 1'b0;
            bcp_free_initial       <= 1'b0;
            bcp_assignment_initial <= 1'b0;
            vst_sel                <= 1'b0;
            bcp_work_en            <= 1'b0;
            w_en                   <= 1'b0;
            conflict_analysis_en   <= 1'b0;
            sel_next               <= 1'b0;
            rw_en                  <= 1'b0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
        end else begin
            state  <= nxt;
            status <= nxt_status;
            timer  <= (state == EVAL) ? timer + TMR_W'(1) : '0;
            if (state == IDLE && nxt == REQ)
                imp_count <= '0;
            else if (state == WR)
                imp_count <= imp_count + CNT_W'(1);
            bcp_request            <= (nxt == REQ);
            bcp_free_initial       <= (nxt == LD_FREE);
            bcp_assignment_initial <= (nxt == LD_ASGN);
            vst_sel                <= (nxt == LD_ASGN);
            bcp_work_en            <= (nxt == FETCH);
            w_en                   <= (nxt == CAPT);
            conflict_analysis_en   <= (nxt == CONF);
            sel_next               <= (nxt == SEL);
            rw_en                  <= (nxt == WR);
            busy                   <= (nxt != IDLE);
            done                   <= (nxt == FIN);
        end
    end

endmodule
